// File: rtl/pwl_act_simd.sv
// LANES-wide piecewise-linear sigmoid/tanh on Q5.11 data in a 3-stage pipeline with valid/ready backpressure.
// Define PWL_ROUND_EN to get round-half-up in the execute stage (the default build uses a floor shift).
module pwl_act_simd #(
    parameter int LANES  = 2,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*DATA_W-1:0]   x_in,
    input  logic                      mode_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [LANES*DATA_W-1:0]   y_out,
    output logic [LANES-1:0]          sat_out,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic signed [DATA_W-1:0] SAT_HI = DATA_W'(12288);
    localparam logic signed [DATA_W-1:0] SAT_LO = DATA_W'(-12288);
    localparam logic signed [DATA_W-1:0] SEG_HI = DATA_W'(4096);
    localparam logic signed [DATA_W-1:0] SEG_LO = DATA_W'(-4096);

    logic advance;

    logic                     s1_valid, s1_mode;
    logic signed [DATA_W-1:0] s1_xs [LANES];
    logic signed [DATA_W-1:0] s1_m  [LANES];
    logic signed [DATA_W-1:0] s1_c  [LANES];
    logic [LANES-1:0]         s1_lo, s1_hi;

    logic                     s2_valid, s2_mode;
    logic signed [DATA_W-1:0] s2_s  [LANES];
    logic [LANES-1:0]         s2_lo, s2_hi;

    logic signed [DATA_W-1:0] xs_n  [LANES];
    logic signed [DATA_W-1:0] m_n   [LANES];
    logic signed [DATA_W-1:0] c_n   [LANES];
    logic [LANES-1:0]         lo_n, hi_n;
    logic signed [DATA_W-1:0] s_n   [LANES];
    logic [LANES*DATA_W-1:0]  y_n;
    logic [LANES-1:0]         sat_n;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance & !rst;

    // Stage 1: optional x2 prescale for tanh, then segment decode.
    always_comb begin
        logic signed [DATA_W-1:0] xv;
        logic signed [DATA_W-1:0] xsv;
        xs_n = '{default: '0};
        m_n  = '{default: '0};
        c_n  = '{default: '0};
        lo_n = '0;
        hi_n = '0;
        xv   = '0;
        xsv  = '0;
        for (int i = 0; i < LANES; i++) begin
            xv = x_in[i*DATA_W +: DATA_W];
            if (!mode_in) begin
                xsv = xv;
            end else if (xv[DATA_W-1] != xv[DATA_W-2]) begin
                xsv = xv[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                xsv = {xv[DATA_W-2:0], 1'b0};
            end
            lo_n[i] = xsv < SAT_LO;
            hi_n[i] = xsv > SAT_HI;
            if (xsv < SEG_LO) begin
                m_n[i] = DATA_W'(60);
                c_n[i] = DATA_W'(364);
            end else if (xsv < SEG_HI) begin
                m_n[i] = DATA_W'(390);
                c_n[i] = DATA_W'(1024);
            end else begin
                m_n[i] = DATA_W'(60);
                c_n[i] = DATA_W'(1684);
            end
            xs_n[i] = xsv;
        end
    end

    // Stage 2: slope multiply, Q-shift back to Q5.11, add intercept.
    always_comb begin
        logic signed [31:0] p;
        logic signed [31:0] q;
        s_n = '{default: '0};
        p   = '0;
        q   = '0;
        for (int i = 0; i < LANES; i++) begin
            p = 32'(s1_xs[i]) * 32'(s1_m[i]);
`ifdef PWL_ROUND_EN
            q = ((p + (32'sd1 <<< (FRAC_W-1))) >>> FRAC_W) + 32'(s1_c[i]);
`else
            q = (p >>> FRAC_W) + 32'(s1_c[i]);
`endif
            s_n[i] = q[DATA_W-1:0];
        end
    end

    // Stage 3: saturation substitution and tanh remap 2*sig - 1.0.
    always_comb begin
        logic signed [DATA_W-1:0] sig;
        logic signed [DATA_W-1:0] t;
        y_n   = '0;
        sat_n = s2_lo | s2_hi;
        sig   = '0;
        t     = '0;
        for (int i = 0; i < LANES; i++) begin
            sig = s2_lo[i] ? DATA_W'(5) : (s2_hi[i] ? DATA_W'(2043) : s2_s[i]);
            t   = (sig <<< 1) - DATA_W'(2048);
            y_n[i*DATA_W +: DATA_W] = s2_mode ? t : sig;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_mode   <= 1'b0;
            s1_xs     <= '{default: '0};
            s1_m      <= '{default: '0};
            s1_c      <= '{default: '0};
            s1_lo     <= '0;
            s1_hi     <= '0;
            s2_valid  <= 1'b0;
            s2_mode   <= 1'b0;
            s2_s      <= '{default: '0};
            s2_lo     <= '0;
            s2_hi     <= '0;
            out_valid <= 1'b0;
            y_out     <= '0;
            sat_out   <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_mode   <= mode_in;
            s1_xs     <= xs_n;
            s1_m      <= m_n;
            s1_c      <= c_n;
            s1_lo     <= lo_n;
            s1_hi     <= hi_n;
            s2_valid  <= s1_valid;
            s2_mode   <= s1_mode;
            s2_s      <= s_n;
            s2_lo     <= s1_lo;
            s2_hi     <= s1_hi;
            out_valid <= s2_valid;
            y_out     <= y_n;
            sat_out   <= sat_n;
        end
    end

endmodule
